vend_controller: RTL

//   Top-level sequencer for the two-item vending machine. Owns the shared coin path and the change

---
 rtl/vend_if.sv | 27 ++
 rtl/vend_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vend_if.sv
// Coin/selection inputs and dispense/hopper outputs of the vending sequencer.
// The front panel side drives the master modport; vend_controller takes the slave modport.
interface vend_if #(
  parameter int CREDIT_W = 4
);
  logic                nickel_in;
  logic                dime_in;
  logic                sel_a;
  logic                sel_b;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                dispense_a;
  logic                dispense_b;
  logic                nickel_out;
  logic                coin_reject;
  logic                busy;

  modport master (
    output nickel_in, dime_in, sel_a, sel_b, cancel,
    input  credit, dispense_a, dispense_b, nickel_out, coin_reject, busy
  );

  modport slave (
    input  nickel_in, dime_in, sel_a, sel_b, cancel,
    output credit, dispense_a, dispense_b, nickel_out, coin_reject, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Two-item vending sequencer: collects nickel/dime credit, latches a selection,
// pulses one dispense output, then pays change or refunds as serial nickel pulses.
module vend_controller #(
  parameter int CREDIT_W    = 4,
  parameter int PRICE_A     = 3,
  parameter int PRICE_B     = 4,
  parameter int MAX_CREDIT  = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input logic  clock,
  input logic  reset,
  vend_if.slave vif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [TMO_W-1:0]    TMO_MAX   = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE, S_REFUND} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B} sel_t;

  state_t              state_q, state_d;
  sel_t                sel_q, sel_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rej_d;
  logic                coin_any;
  logic [1:0]          coin_amt;
  logic [CREDIT_W:0]   sum;

  function automatic logic [CREDIT_W-1:0] price_of(input sel_t s);
    case (s)
      SEL_A:   price_of = PRICE_A_C;
      SEL_B:   price_of = PRICE_B_C;
      default: price_of = '0;
    endcase
  endfunction

  assign coin_any = vif.nickel_in | vif.dime_in;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    rej_d    = 1'b0;
    coin_amt = vif.dime_in ? 2'd2 : (vif.nickel_in ? 2'd1 : 2'd0);
    sum      = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_amt};

    case (state_q)
      S_IDLE, S_COLLECT: begin
        // A simultaneous nickel is dropped in favour of the dime and handed back.
        rej_d = vif.nickel_in & vif.dime_in;
        if (sum > MAX_C) rej_d = coin_any;
        else             credit_d = sum[CREDIT_W-1:0];

        if (vif.sel_a)      sel_d = SEL_A;
        else if (vif.sel_b) sel_d = SEL_B;

        if (coin_any | vif.sel_a | vif.sel_b | vif.cancel) tmo_d = '0;
        else if (state_q == S_COLLECT)                     tmo_d = tmo_q + 1'b1;

        if (vif.cancel) begin
          // Cancel wins: any coin in the same cycle goes back, selection is dropped.
          credit_d = credit_q;
          rej_d    = coin_any;
          sel_d    = SEL_NONE;
          state_d  = (credit_q != '0) ? S_REFUND : S_IDLE;
        end else if (sel_d != SEL_NONE && credit_d >= price_of(sel_d)) begin
          state_d = S_DISPENSE;
        end else if (state_q == S_COLLECT && tmo_d == TMO_MAX) begin
          sel_d   = SEL_NONE;
          tmo_d   = '0;
          state_d = (credit_d != '0) ? S_REFUND : S_IDLE;
        end else begin
          state_d = (credit_d != '0 || sel_d != SEL_NONE) ? S_COLLECT : S_IDLE;
        end
      end

      S_DISPENSE: begin
        rej_d    = coin_any;
        credit_d = credit_q - price_of(sel_q);
        sel_d    = SEL_NONE;
        tmo_d    = '0;
        state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE, S_REFUND: begin
        // Entered only with credit>0, so each cycle here is one nickel paid out.
        rej_d = coin_any;
        if (credit_q != '0) credit_d = credit_q - 1'b1;
        if (credit_q <= {{(CREDIT_W-1){1'b0}}, 1'b1}) state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        sel_d    = SEL_NONE;
        credit_d = '0;
        tmo_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      sel_q           <= SEL_NONE;
      credit_q        <= '0;
      tmo_q           <= '0;
      vif.dispense_a  <= 1'b0;
      vif.dispense_b  <= 1'b0;
      vif.nickel_out  <= 1'b0;
      vif.coin_reject <= 1'b0;
      vif.busy        <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      credit_q        <= credit_d;
      tmo_q           <= tmo_d;
      vif.dispense_a  <= (state_d == S_DISPENSE) && (sel_d == SEL_A);
      vif.dispense_b  <= (state_d == S_DISPENSE) && (sel_d == SEL_B);
      vif.nickel_out  <= (state_d == S_CHANGE) || (state_d == S_REFUND);
      vif.coin_reject <= rej_d;
      vif.busy        <= (state_d == S_DISPENSE) || (state_d == S_CHANGE) ||
                         (state_d == S_REFUND);
    end
  end

  assign vif.credit = credit_q;

endmodule
